// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency line memory for cache fill/writeback, optional LINE_MEM_STATS_EN request counters
module line_mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [15:0]               req_addr,
  input  logic [16*LINE_WORDS-1:0]  req_wdata,
  output logic                      resp_valid,
  output logic [16*LINE_WORDS-1:0]  resp_rdata
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [15:0]               num_read,
  output logic [15:0]               num_write
`endif
);
  localparam int IDX_BITS = ADDR_BITS - 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt;
  logic wr;
  logic [IDX_BITS-1:0] idx;
  logic [16*LINE_WORDS-1:0] wdata;
  logic [16*LINE_WORDS-1:0] mem [2**IDX_BITS];
  logic accept, done;
  logic unused;
  assign unused = ^{req_addr[15:ADDR_BITS], req_addr[1:0]};
  assign req_ready = state == IDLE && !reset;
  assign resp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  assign done = state == WAIT && cnt == 8'd0;
  always_comb begin
    state_nxt = state == IDLE ? (accept ? WAIT : IDLE) : state == WAIT ? (done ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      wr <= 1'b0;
      idx <= '0;
      wdata <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        wr <= req_write;
        idx <= req_addr[ADDR_BITS-1:2];
        wdata <= req_wdata;
        cnt <= 8'(MEM_LATENCY - 1);
      end else if (state == WAIT && !done) cnt <= cnt - 8'd1;
      if (done) resp_rdata <= wr ? wdata : mem[idx];
    end
  end
  // array is deliberately not reset; reset only suppresses an in-flight write
  always_ff @(posedge clk) begin
    if (!reset && done && wr) mem[idx] <= wdata;
  end
`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      num_read <= '0;
      num_write <= '0;
    end else if (accept) begin
      num_read <= num_read + 16'(!req_write);
      num_write <= num_write + 16'(req_write);
    end
  end
`endif
endmodule
